// File: rtl/search_unique_bit_sequence_multi.sv
// Sliding-window correlator: compares the last LEN demodulated bits against NUM_SEQUENCE
// candidates, reports the closest one within a Hamming threshold, then locks for lock_len bits.
module search_unique_bit_sequence_multi #(
    parameter int LEN_UNIQUE_BIT_SEQUENCE = 32,
    parameter int NUM_SEQUENCE            = 2,
    parameter int ERR_WIDTH               = 3,
    parameter int LOCK_WIDTH              = 12,
    localparam int CNT_W = $clog2(LEN_UNIQUE_BIT_SEQUENCE + 1),
    localparam int IDX_W = (NUM_SEQUENCE > 1) ? $clog2(NUM_SEQUENCE) : 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            search_enable,
    input  logic                                            phy_bit,
    input  logic                                            bit_valid,
    input  logic [NUM_SEQUENCE*LEN_UNIQUE_BIT_SEQUENCE-1:0] unique_bit_sequence,
    input  logic [ERR_WIDTH-1:0]                            max_bit_error,
    input  logic [LOCK_WIDTH-1:0]                           lock_len,
    output logic                                            hit_flag,
    output logic [IDX_W-1:0]                                hit_idx,
    output logic [CNT_W-1:0]                                hit_bit_error,
    output logic [31:0]                                     hit_bit_pos,
    output logic                                            locked,
    output logic [31:0]                                     bit_count,
    output logic [1:0]                                      state_dbg
);

    localparam int LEN   = LEN_UNIQUE_BIT_SEQUENCE;
    localparam int CMP_W = (CNT_W > ERR_WIDTH) ? CNT_W : ERR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LOCK_WIDTH-1:0] lock_cnt_q, lock_cnt_d;
    logic                  hit_d;

    logic [LEN-1:0]   window;
    logic [CNT_W-1:0] fill;
    logic             s0_valid;
    logic             s1_valid;
    logic             s1_full;
    logic [31:0]      s1_pos;
    logic [CNT_W-1:0] s1_err   [NUM_SEQUENCE];
    logic [CNT_W-1:0] err_next [NUM_SEQUENCE];

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [CNT_W-1:0] win_err;
    logic             flush;
    logic             accept;
    logic [LOCK_WIDTH:0] lock_inc;

    // bit_valid is a one-cycle qualifier with no backpressure: a bit is taken on every
    // edge where bit_valid=1 and the block is out of IDLE; nothing upstream ever stalls.
    assign flush  = !search_enable || (state_q == ST_IDLE);
    assign accept = bit_valid && !flush;

    always_comb begin
        for (int k = 0; k < NUM_SEQUENCE; k++) begin
            err_next[k] = '0;
            for (int b = 0; b < LEN; b++) begin
                err_next[k] = err_next[k]
                            + CNT_W'(window[b] ^ unique_bit_sequence[k*LEN + b]);
            end
        end
    end

    // S0 shifts the window, S1 registers the per-sequence distances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window    <= '0;
            fill      <= '0;
            bit_count <= '0;
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_full   <= 1'b0;
            s1_pos    <= '0;
            for (int k = 0; k < NUM_SEQUENCE; k++) s1_err[k] <= '0;
        end else if (flush) begin
            window    <= '0;
            fill      <= '0;
            bit_count <= '0;
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_full   <= 1'b0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                window    <= {phy_bit, window[LEN-1:1]};
                bit_count <= bit_count + 32'd1;
                if (fill != CNT_W'(LEN)) fill <= fill + CNT_W'(1);
            end
            s1_valid <= s0_valid;
            s1_full  <= (fill == CNT_W'(LEN));
            s1_pos   <= bit_count;
            for (int k = 0; k < NUM_SEQUENCE; k++) s1_err[k] <= err_next[k];
        end
    end

    // Strict '<' keeps the lowest index on equal distances.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_err   = '0;
        for (int k = 0; k < NUM_SEQUENCE; k++) begin
            if ((CMP_W'(s1_err[k]) <= CMP_W'(max_bit_error)) &&
                (!win_found || (s1_err[k] < win_err))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
                win_err   = s1_err[k];
            end
        end
    end

    assign lock_inc = {1'b0, lock_cnt_q} + (LOCK_WIDTH+1)'(1);

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        hit_d      = 1'b0;
        if (!search_enable) begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_SEARCH;
                    lock_cnt_d = '0;
                end
                ST_SEARCH: begin
                    if (s1_valid && s1_full && win_found) begin
                        hit_d = 1'b1;
                        if (lock_len != '0) state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // '>=' also releases the lock if lock_len is lowered mid-lock.
                    if (s1_valid) begin
                        if (lock_inc >= {1'b0, lock_len}) begin
                            state_d    = ST_SEARCH;
                            lock_cnt_d = '0;
                        end else begin
                            lock_cnt_d = lock_inc[LOCK_WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            lock_cnt_q    <= '0;
            hit_flag      <= 1'b0;
            hit_idx       <= '0;
            hit_bit_error <= '0;
            hit_bit_pos   <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            hit_flag   <= hit_d;
            if (hit_d) begin
                hit_idx       <= win_idx;
                hit_bit_error <= win_err;
                hit_bit_pos   <= s1_pos;
            end
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign state_dbg = state_q;

endmodule
